// File: rtl/ysyx_24110006_mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter with a response watchdog.
// Define ARBITER_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module ysyx_24110006_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_resp,
    output logic [31:0] o_if_rdata,
    output logic        o_if_err,
    input  logic        i_ls_req,
    input  logic        i_ls_wen,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    input  logic [3:0]  i_ls_wmask,
    output logic        o_ls_resp,
    output logic [31:0] o_ls_rdata,
    output logic        o_ls_err,
    output logic        o_mem_req,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wmask,
    input  logic        i_mem_resp,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_err
);

    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyLs} state_e;

    localparam logic [7:0] WdLimit = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wd_q, wd_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        grant_ls;
    logic        resp;
    logic        err;
    logic [31:0] rdata;
`ifdef ARBITER_RR_EN
    logic        last_ls_q, last_ls_d;
`endif

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        grant_ls  = 1'b0;
        resp      = 1'b0;
        err       = 1'b0;
        rdata     = 32'h0;
`ifdef ARBITER_RR_EN
        last_ls_d = last_ls_q;
`endif
        case (state_q)
            StIdle: begin
`ifdef ARBITER_RR_EN
                // On a tie the master that did not win last time goes first.
                grant_ls = i_ls_req && (!i_if_req || !last_ls_q);
`else
                grant_ls = i_ls_req;
`endif
                if (i_if_req || i_ls_req) begin
                    wd_d = 8'h0;
`ifdef ARBITER_RR_EN
                    last_ls_d = grant_ls;
`endif
                    if (grant_ls) begin
                        state_d = StBusyLs;
                        wen_d   = i_ls_wen;
                        addr_d  = i_ls_addr;
                        wdata_d = i_ls_wdata;
                        wmask_d = i_ls_wmask;
                    end else begin
                        state_d = StBusyIf;
                        wen_d   = 1'b0;
                        addr_d  = i_if_addr;
                        wdata_d = 32'h0;
                        wmask_d = 4'h0;
                    end
                end
            end
            StBusyIf, StBusyLs: begin
                if (i_mem_resp) begin
                    resp    = 1'b1;
                    err     = i_mem_err;
                    rdata   = i_mem_rdata;
                    state_d = StIdle;
                end else if (wd_q == WdLimit) begin
                    // Hung slave: answer the master with an access fault.
                    resp    = 1'b1;
                    err     = 1'b1;
                    state_d = StIdle;
                end else begin
                    wd_d = wd_q + 8'h1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_mem_req   = (state_q != StIdle);
    assign o_mem_wen   = wen_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_wmask = wmask_q;

    assign o_if_resp  = resp && (state_q == StBusyIf);
    assign o_if_err   = err && (state_q == StBusyIf);
    assign o_if_rdata = (state_q == StBusyIf) ? rdata : 32'h0;
    assign o_ls_resp  = resp && (state_q == StBusyLs);
    assign o_ls_err   = err && (state_q == StBusyLs);
    assign o_ls_rdata = (state_q == StBusyLs) ? rdata : 32'h0;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= StIdle;
            wd_q      <= 8'h0;
            wen_q     <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wmask_q   <= 4'h0;
`ifdef ARBITER_RR_EN
            last_ls_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
`ifdef ARBITER_RR_EN
            last_ls_q <= last_ls_d;
`endif
        end
    end

endmodule
